// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Queues ALU commands in a small FIFO, drives a TinyALU-style start/done
// datapath one command at a time, and returns each result (or a timeout /
// illegal-opcode error) on a valid/ready response channel in command order.

module alu_cmd_sequencer #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [2:0]                cmd_op,
   input  logic [DATA_W-1:0]         cmd_a,
   input  logic [DATA_W-1:0]         cmd_b,

   output logic                      alu_start,
   output logic [2:0]                alu_op,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   output logic                      alu_reset_n,
   input  logic                      alu_done,
   input  logic [2*DATA_W-1:0]       alu_result,

   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [2:0]                rsp_op,
   output logic [2*DATA_W-1:0]       rsp_result,
   output logic                      rsp_err,

   output logic [$clog2(DEPTH):0]    level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_RST = 3'b111;
   localparam logic [2:0] OP_BAD5 = 3'b101;
   localparam logic [2:0] OP_BAD6 = 3'b110;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      ARST,
      RESP
   } state_t;

   // ------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------
   logic [2:0]        fifo_op [DEPTH];
   logic [DATA_W-1:0] fifo_a  [DEPTH];
   logic [DATA_W-1:0] fifo_b  [DEPTH];

   logic [PTR_W:0]    wr_ptr;
   logic [PTR_W:0]    rd_ptr;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   logic [2:0]        head_op;
   logic [DATA_W-1:0] head_a;
   logic [DATA_W-1:0] head_b;
   logic              head_illegal;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign cmd_ready = !reset && !full;
   assign push      = cmd_valid && cmd_ready;
   assign level     = wr_ptr - rd_ptr;

   assign head_op      = fifo_op[rd_ptr[PTR_W-1:0]];
   assign head_a       = fifo_a[rd_ptr[PTR_W-1:0]];
   assign head_b       = fifo_b[rd_ptr[PTR_W-1:0]];
   assign head_illegal = (head_op == OP_BAD5) || (head_op == OP_BAD6);

   // FIFO pointers: the extra top bit distinguishes full from empty
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // FIFO storage: plain memory, contents are meaningless until written
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr[PTR_W-1:0]] <= cmd_op;
         fifo_a[wr_ptr[PTR_W-1:0]]  <= cmd_a;
         fifo_b[wr_ptr[PTR_W-1:0]]  <= cmd_b;
      end
   end

   // ------------------------------------------------------------------
   // Sequencer FSM; all ALU and response pins are registered
   // ------------------------------------------------------------------
   state_t              state;
   state_t              state_d;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_d;

   logic                alu_start_d;
   logic [2:0]          alu_op_d;
   logic [DATA_W-1:0]   alu_a_d;
   logic [DATA_W-1:0]   alu_b_d;
   logic                rsp_valid_d;
   logic [2:0]          rsp_op_d;
   logic [2*DATA_W-1:0] rsp_result_d;
   logic                rsp_err_d;

   // The ALU is held in reset only while the FSM sits in ARST or the block is reset
   assign alu_reset_n = !reset && (state != ARST);

   // Next-state and next-output decode; every register holds its value by default
   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      pop          = 1'b0;
      alu_start_d  = alu_start;
      alu_op_d     = alu_op;
      alu_a_d      = alu_a;
      alu_b_d      = alu_b;
      rsp_valid_d  = rsp_valid;
      rsp_op_d     = rsp_op;
      rsp_result_d = rsp_result;
      rsp_err_d    = rsp_err;

      case (state)
         IDLE: begin
            if (!empty) begin
               pop          = 1'b1;
               cnt_d        = '0;
               rsp_op_d     = head_op;
               rsp_result_d = '0;
               rsp_err_d    = 1'b0;
               if (head_illegal) begin
                  rsp_err_d = 1'b1;
                  state_d   = RESP;
               end else begin
                  alu_op_d = head_op;
                  alu_a_d  = head_a;
                  alu_b_d  = head_b;
                  state_d  = (head_op == OP_RST) ? ARST : ISSUE;
               end
            end
         end

         ISSUE: begin
            alu_start_d = 1'b1;
            cnt_d       = '0;
            state_d     = (alu_op == OP_NOP) ? RESP : WAIT;
         end

         WAIT: begin
            if (alu_done) begin
               alu_start_d  = 1'b0;
               rsp_result_d = alu_result;
               rsp_valid_d  = 1'b1;
               state_d      = RESP;
            end else if (cnt == CNT_LAST) begin
               alu_start_d  = 1'b0;
               rsp_result_d = '0;
               rsp_err_d    = 1'b1;
               rsp_valid_d  = 1'b1;
               state_d      = RESP;
            end else begin
               cnt_d = cnt + CNT_ONE;
            end
         end

         ARST: begin
            if (cnt == CNT_ONE) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt + CNT_ONE;
            end
         end

         RESP: begin
            if (!rsp_valid) begin
               rsp_valid_d = 1'b1;
               alu_start_d = 1'b0;
            end else if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and output registers; reset aborts any command in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         alu_start  <= 1'b0;
         alu_op     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_valid  <= 1'b0;
         rsp_op     <= '0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         alu_start  <= alu_start_d;
         alu_op     <= alu_op_d;
         alu_a      <= alu_a_d;
         alu_b      <= alu_b_d;
         rsp_valid  <= rsp_valid_d;
         rsp_op     <= rsp_op_d;
         rsp_result <= rsp_result_d;
         rsp_err    <= rsp_err_d;
      end
   end

endmodule
